decode_ctrl: RTL
================

# decode_ctrl

Registered decode/control stage for the lab RISC-V core. Accepts one 32-bit instruction per cycle over a valid/ready handshake and emits a one-cycle-latency registered control bundle for the datapath: ALU op, source selects, writeback select, destination and immediate. It also owns the memory-mapped GPIO output register written by `csrrw`, stalls issue for a parametrised multiply latency, and counts illegal instructions.

## Interface
- `XLEN`, 32: datapath width; `imm`, `rs1_data`, `gpio_out` and `csr_rdata` are `XLEN` bits.
- `MUL_CYCLES`, 3: multiply latency in cycles, ≥1; 1 means no stall.
- `GPIO_CSR`, 12'hF02: CSR address mapped to the GPIO output register.
- `GPIO_RESET`, 0: reset value of `gpio_out`.
- `CNT_W`, 8: width of the illegal-instruction counter.

Ports:
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `instr_valid` in 1: `instr` is valid.
- `instr` in 32: instruction word.
- `instr_ready` out 1: stage can accept an instruction.
- `rs1_data` in XLEN: rs1 value, sampled at accept (used by `csrrw`).
- `ctrl_valid` out 1: control bundle valid for this cycle.
- `alusrc` out 1: 1 = immediate operand B, 0 = rs2.
- `regwrite` out 1: register-file write enable.
- `regsel` out 2: writeback source. 00 = `csr_rdata`, 01 = `imm` (lui), 10 = ALU result.
- `op` out 4: ALU op (encodings under Operation).
- `rd` out 5: destination register.
- `imm` out XLEN: sign-extended I-immediate, U-immediate for lui, or zero-extended shamt for shifts.
- `csr_rdata` out XLEN: old `gpio_out` value captured at the `csrrw`.
- `gpio_we` out 1: one-cycle pulse when `gpio_out` is written.
- `gpio_out` out XLEN: GPIO output register.
- `mul_busy` out 1: multiply stall in progress.
- `illegal` out 1: current bundle is an illegal instruction.
- `illegal_cnt` out CNT_W: saturating count of illegal instructions.

## Operation
- Accept occurs when `instr_valid && instr_ready`. All outputs are registered.
- Supported instructions:
  - R-type: add, sub, and, or, xor, sll, srl, sra, slt, sltu, mul, mulh, mulhu.
  - I-type: addi, andi, ori, xori, slli, srli, srai.
  - U-type: lui.
  - System: `csrrw` to `GPIO_CSR` only.
- Op encodings: and 0000, or 0001, xor 0010, add 0011, sub 0100, mul 0101, mulh 0110, mulhu 0111, sll 1000, srl 1001, sra 1010, slt 1100, sltu 1101.
- R-type: `alusrc`=0, `regsel`=10.
- I-type: `alusrc`=1, `regsel`=10.
  - Shift-immediates require imm[11:5]=0000000 (slli, srli) or 0100000 (srai); anything else is illegal.
- lui: `regsel`=01, `imm`={instr[31:12],12'b0}, `op`=0000, `alusrc`=0.
- csrrw to `GPIO_CSR`:
  - `csr_rdata` is loaded with the old `gpio_out`; `gpio_out` is loaded with `rs1_data`.
  - `gpio_we` pulses; `regsel`=00.
  - A csrrw to any other CSR address is illegal.
- `regwrite` is forced to 0 whenever `rd`=0. A csrrw with `rd`=0 still writes the GPIO register.
- Illegal instruction (any unlisted opcode/funct3/funct7 combination):
  - `ctrl_valid`=1, `illegal`=1.
  - `regwrite`=0, `gpio_we`=0.
  - `illegal_cnt` increments and saturates at all-ones.
- States:
  - IDLE: `instr_ready`=1.
  - MUL_WAIT: `instr_ready`=0, `mul_busy`=1, down-counter runs.
- Transitions:
  - Accepting mul/mulh/mulhu with `MUL_CYCLES`>1: IDLE→MUL_WAIT, counter loaded with `MUL_CYCLES`-2.
  - MUL_WAIT→IDLE when the counter reaches 0.
  - `MUL_CYCLES`=1: the FSM never leaves IDLE.
- Cycles with no accept: `ctrl_valid`=0 and `gpio_we`=0; all other bundle fields hold their last value.

## Timing
- Latency: instruction accepted at edge t → bundle visible with `ctrl_valid`=1 for exactly one cycle after edge t (cycle t+1).
- Back-to-back accepts give back-to-back `ctrl_valid`.
- Multiply accepted at t:
  - `instr_ready` is low for cycles t+1 … t+`MUL_CYCLES`-1.
  - The next accept is possible at edge t+`MUL_CYCLES`.
- `gpio_out` changes at the same edge where `gpio_we` rises.
  - A csrrw immediately after another csrrw reads the value written by the first.
- Reset values:
  - All outputs 0 except `gpio_out`=`GPIO_RESET` and `instr_ready`=1.
  - FSM in IDLE; counter 0; `illegal_cnt`=0.
- Reset asserted mid-MUL_WAIT: the stall aborts immediately. After release, `instr_ready`=1 on the first cycle; no stale `ctrl_valid`.
- `instr_valid` while `instr_ready`=0: ignored, nothing captured. The upstream stage must hold the instruction.

## Test plan
- addi x5,x0,-1 (0xFFF00293) → next cycle: `ctrl_valid`=1, `alusrc`=1, `regwrite`=1, `regsel`=10, `op`=0011, `rd`=5, `imm`=0xFFFFFFFF.
- lui x1,0x12345 followed by add x0,x1,x1 back-to-back → two consecutive valid bundles:
  - first: `regsel`=01, `imm`=0x12345000;
  - second: `regwrite`=0 because `rd`=0.
- mul x3,x1,x2 with `MUL_CYCLES`=3, `instr_valid` held high with an xor queued →
  - mul bundle at t+1 with `op`=0101;
  - `instr_ready` low at t+1 and t+2;
  - xor accepted at t+3.
- csrrw x2,0xF02,x1 with `rs1_data`=0xA5, then csrrw x3,0xF02,x0 with `rs1_data`=0 →
  - first: `gpio_we` pulse, `gpio_out`=0xA5, `csr_rdata`=0;
  - second: `csr_rdata`=0xA5, `gpio_out`=0.
- Word 0xFFFFFFFF issued 260 times with `CNT_W`=8 → every bundle has `illegal`=1 and `regwrite`=0; `illegal_cnt` saturates at 255.
- Assert `rst` during MUL_WAIT → `instr_ready`=1, `mul_busy`=0, `gpio_out`=`GPIO_RESET`, `illegal_cnt`=0 immediately.

Source files
------------

// File: rtl/decode_ctrl.sv
// Registered decode/control stage: one instruction per cycle in, one-cycle-latency
// control bundle out, plus the CSR-mapped GPIO register, multiply stall and illegal counter.
module decode_ctrl #(
  parameter int              XLEN       = 32,
  parameter int              MUL_CYCLES = 3,
  parameter logic [11:0]     GPIO_CSR   = 12'hF02,
  parameter logic [XLEN-1:0] GPIO_RESET = '0,
  parameter int              CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  input  logic [XLEN-1:0]   rs1_data,
  output logic              ctrl_valid,
  output logic              alusrc,
  output logic              regwrite,
  output logic [1:0]        regsel,
  output logic [3:0]        op,
  output logic [4:0]        rd,
  output logic [XLEN-1:0]   imm,
  output logic [XLEN-1:0]   csr_rdata,
  output logic              gpio_we,
  output logic [XLEN-1:0]   gpio_out,
  output logic              mul_busy,
  output logic              illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_SYS = 7'b1110011;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_XOR   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_MULH  = 4'b0110;
  localparam logic [3:0] OP_MULHU = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_SLT   = 4'b1100;
  localparam logic [3:0] OP_SLTU  = 4'b1101;

  localparam logic [1:0] SEL_CSR = 2'b00;
  localparam logic [1:0] SEL_IMM = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  // Counter holds MUL_CYCLES-2 at most; the stall lasts counter+1 cycles.
  localparam int              MC_W      = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES - 1) : 1;
  localparam logic [MC_W-1:0] MC_LOAD   = (MUL_CYCLES > 2) ? MC_W'(MUL_CYCLES - 2) : '0;
  localparam logic            MUL_STALL = (MUL_CYCLES > 1);

  typedef enum logic {IDLE, MUL_WAIT} state_t;

  state_t          state_q, state_d;
  logic [MC_W-1:0] cnt_q, cnt_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       accept;

  logic            illegal_p0;
  logic            alusrc_p0;
  logic [1:0]      regsel_p0;
  logic [3:0]      op_p0;
  logic [XLEN-1:0] imm_p0;
  logic            is_csr_p0;
  logic            is_mul_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign accept = instr_valid && instr_ready;

  // ---- stage p0: combinational decode of the offered instruction ----
  always_comb begin
    illegal_p0 = 1'b1;
    alusrc_p0  = 1'b0;
    regsel_p0  = SEL_ALU;
    op_p0      = OP_AND;
    imm_p0     = '0;
    is_csr_p0  = 1'b0;
    is_mul_p0  = 1'b0;
    case (opcode)
      OPC_OP: begin
        illegal_p0 = 1'b0;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: op_p0 = OP_ADD;
          {7'b0100000, 3'b000}: op_p0 = OP_SUB;
          {7'b0000000, 3'b111}: op_p0 = OP_AND;
          {7'b0000000, 3'b110}: op_p0 = OP_OR;
          {7'b0000000, 3'b100}: op_p0 = OP_XOR;
          {7'b0000000, 3'b001}: op_p0 = OP_SLL;
          {7'b0000000, 3'b101}: op_p0 = OP_SRL;
          {7'b0100000, 3'b101}: op_p0 = OP_SRA;
          {7'b0000000, 3'b010}: op_p0 = OP_SLT;
          {7'b0000000, 3'b011}: op_p0 = OP_SLTU;
          {7'b0000001, 3'b000}: begin op_p0 = OP_MUL;   is_mul_p0 = 1'b1; end
          {7'b0000001, 3'b001}: begin op_p0 = OP_MULH;  is_mul_p0 = 1'b1; end
          {7'b0000001, 3'b011}: begin op_p0 = OP_MULHU; is_mul_p0 = 1'b1; end
          default:              illegal_p0 = 1'b1;
        endcase
      end
      OPC_IMM: begin
        illegal_p0 = 1'b0;
        alusrc_p0  = 1'b1;
        imm_p0     = XLEN'($signed(instr[31:20]));
        case (funct3)
          3'b000: op_p0 = OP_ADD;
          3'b100: op_p0 = OP_XOR;
          3'b110: op_p0 = OP_OR;
          3'b111: op_p0 = OP_AND;
          3'b001: begin
            op_p0      = OP_SLL;
            imm_p0     = XLEN'(instr[24:20]);
            illegal_p0 = (funct7 != 7'b0000000);
          end
          3'b101: begin
            op_p0      = (funct7 == 7'b0100000) ? OP_SRA : OP_SRL;
            imm_p0     = XLEN'(instr[24:20]);
            illegal_p0 = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          end
          default: illegal_p0 = 1'b1;
        endcase
      end
      OPC_LUI: begin
        illegal_p0 = 1'b0;
        regsel_p0  = SEL_IMM;
        imm_p0     = XLEN'($signed({instr[31:12], 12'b0}));
      end
      OPC_SYS: begin
        if (funct3 == 3'b001 && instr[31:20] == GPIO_CSR) begin
          illegal_p0 = 1'b0;
          regsel_p0  = SEL_CSR;
          is_csr_p0  = 1'b1;
        end
      end
      default: illegal_p0 = 1'b1;
    endcase
  end

  // ---- issue FSM: stalls acceptance while a multiply is in flight ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (MUL_STALL && accept && is_mul_p0 && !illegal_p0) begin
          state_d = MUL_WAIT;
          cnt_d   = MC_LOAD;
        end
      end
      MUL_WAIT: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign instr_ready = (state_q == IDLE);
  assign mul_busy    = (state_q == MUL_WAIT);

  // ---- stage p1: registered control bundle and GPIO register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_valid  <= 1'b0;
      alusrc      <= 1'b0;
      regwrite    <= 1'b0;
      regsel      <= 2'b00;
      op          <= 4'b0000;
      rd          <= 5'd0;
      imm         <= '0;
      csr_rdata   <= '0;
      gpio_we     <= 1'b0;
      gpio_out    <= GPIO_RESET;
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      ctrl_valid <= accept;
      gpio_we    <= accept && is_csr_p0;
      if (accept) begin
        alusrc   <= alusrc_p0;
        regwrite <= !illegal_p0 && (instr[11:7] != 5'd0);
        regsel   <= regsel_p0;
        op       <= op_p0;
        rd       <= instr[11:7];
        imm      <= imm_p0;
        illegal  <= illegal_p0;
        if (is_csr_p0) begin
          csr_rdata <= gpio_out;
          gpio_out  <= rs1_data;
        end
        if (illegal_p0) illegal_cnt <= sat_inc(illegal_cnt);
      end
    end
  end

endmodule
